// File: rtl/button_debounce_pkg.sv
// Shared types and parameter limits for the button debouncer.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } deb_state_t;

  localparam int WIDTH_MIN         = 1;
  localparam int WIDTH_MAX         = 16;
  localparam int STABLE_CYCLES_MIN = 2;
  localparam int SYNC_STAGES_MIN   = 2;

endpackage

// File: rtl/button_debounce_channel.sv
// One debounce channel: synchronizer chain, qualification FSM and counter.
// Edge pulses exist only when BUTTON_DEBOUNCE_EDGE_EN is defined.
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_t             state;
  logic [CW-1:0]          cnt;

  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};

  assign sync = sync_q[SYNC_STAGES-1];

  // level is updated on entry to HIGH / LOW so it tracks {HIGH, WAIT_LOW}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      rise  <= 1'b0;
      fall  <= 1'b0;
`endif
    end else begin
`ifdef BUTTON_DEBOUNCE_EDGE_EN
      rise <= 1'b0;
      fall <= 1'b0;
`endif
      unique case (state)
        ST_LOW:
          if (sync) begin state <= ST_WAIT_HIGH; cnt <= CNT_ONE; end
          else      cnt <= '0;
        ST_WAIT_HIGH:
          if (!sync) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HIGH;
            cnt   <= '0;
            level <= 1'b1;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
            rise  <= 1'b1;
`endif
          end else cnt <= cnt + CNT_ONE;
        ST_HIGH:
          if (!sync) begin state <= ST_WAIT_LOW; cnt <= CNT_ONE; end
          else       cnt <= '0;
        ST_WAIT_LOW:
          if (sync) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
            fall  <= 1'b1;
`endif
          end else cnt <= cnt + CNT_ONE;
      endcase
    end
  end

`ifndef BUTTON_DEBOUNCE_EDGE_EN
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel button debouncer; WIDTH independent channels.
// Define BUTTON_DEBOUNCE_EDGE_EN to get RISE/FALL pulses, otherwise they are 0.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] LEVEL,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      STABLE_CYCLES < STABLE_CYCLES_MIN || SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_param
    $error("button_debounce: parameter out of legal range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk   (CLK),
      .rst   (RST),
      .din   (IN[i]),
      .level (LEVEL[i]),
      .rise  (RISE[i]),
      .fall  (FALL[i])
    );
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter WIDTH, default 4: number of independent input channels; legal range 1..16.
REQ-002 Parameter STABLE_CYCLES, default 1000000: consecutive identical synchronized samples required before a level change is accepted; legal minimum 2.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flop depth per channel; legal minimum 2.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 IN  input  WIDTH  raw asynchronous button/switch inputs, bounce-prone.
REQ-007 LEVEL  output  WIDTH  debounced registered level per channel; feeds the downstream edge/transition stage.
REQ-008 RISE  output  WIDTH  one-cycle pulse per channel on each accepted 0->1 change.
REQ-009 FALL  output  WIDTH  one-cycle pulse per channel on each accepted 1->0 change.

Function
REQ-010 Each IN bit SHALL pass through its own SYNC_STAGES-deep flop chain; only the last stage (SYNC) SHALL be used by the FSM.
REQ-011 Each channel SHALL run an independent FSM with states LOW, WAIT_HIGH, HIGH, WAIT_LOW and a counter of width clog2(STABLE_CYCLES+1).
REQ-012 LOW: SYNC=1 -> WAIT_HIGH with count=1; otherwise stay, count=0.
REQ-013 WAIT_HIGH: SYNC=0 -> LOW, count=0; SYNC=1 and count=STABLE_CYCLES-1 -> HIGH; otherwise count increments.
REQ-014 HIGH and WAIT_LOW SHALL mirror LOW and WAIT_HIGH with SYNC polarity inverted.
REQ-015 LEVEL SHALL be 1 exactly when the FSM is in HIGH or WAIT_LOW, registered, with no combinational path from IN.
REQ-016 The latency from a clean IN step to the LEVEL change SHALL be exactly SYNC_STAGES+STABLE_CYCLES cycles.
REQ-017 A glitch shorter than STABLE_CYCLES synchronized samples SHALL NOT change LEVEL and SHALL restart the qualification count.
REQ-018 RISE (or FALL) SHALL assert in the same cycle LEVEL first shows the new value and SHALL deassert the following cycle; RISE and FALL of one channel SHALL never assert together.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be qualified separately.

Reset
REQ-021 RST SHALL immediately clear all synchronizer flops, force every FSM to LOW, and zero every counter.
REQ-022 During and after RST, LEVEL, RISE and FALL SHALL be 0.
REQ-023 After reset release, an IN held high SHALL produce LEVEL=1 and one RISE pulse exactly SYNC_STAGES+STABLE_CYCLES cycles later.
REQ-024 Reset asserted during WAIT_HIGH or WAIT_LOW SHALL discard the partial count.

Configuration
REQ-025 Macro BUTTON_DEBOUNCE_EDGE_EN defined: RISE and FALL SHALL be generated per REQ-018.
REQ-026 Macro BUTTON_DEBOUNCE_EDGE_EN undefined: RISE and FALL SHALL be tied to constant 0 and the edge logic SHALL be absent; LEVEL behaviour SHALL be unchanged.

Structure
REQ-027 A shared package button_debounce_pkg SHALL hold the FSM state typedef (2-bit encoding of LOW, WAIT_HIGH, HIGH, WAIT_LOW) and the legal-range limits for the parameters.
REQ-028 The per-channel synchronizer, FSM and counter SHALL live in a sub-module debounce_channel, instantiated WIDTH times by a generate loop.

Verification (bench uses WIDTH=4, STABLE_CYCLES=8, SYNC_STAGES=2)
REQ-029 Clean step: IN[0] goes 0->1 and holds -> LEVEL[0]=1 and RISE[0] pulses for one cycle, exactly 10 cycles after the step; other bits stay 0.
REQ-030 Bounce: IN[1] toggles 1,0,1,0 at 3-cycle intervals, then holds 1 -> no LEVEL change during the bounce; LEVEL[1] rises 10 cycles after the final edge.
REQ-031 Glitch: with LEVEL[2]=1, IN[2] is low for 7 cycles, then returns high -> LEVEL[2] stays 1 and FALL[2] never asserts.
REQ-032 Reset mid-qualification: IN[3] goes high, RST pulses 5 cycles later, IN[3] stays high -> all outputs 0 during reset; LEVEL[3] rises 10 cycles after RST deasserts, with a single RISE[3].
REQ-033 Simultaneous: IN=4'b1111 applied in one cycle -> LEVEL=4'b1111 and RISE=4'b1111 in the same cycle; then IN=4'b0000 -> FALL=4'b1111 10 cycles later.
REQ-034 Macro off: repeat the REQ-029 stimulus -> LEVEL identical; RISE and FALL constant 0.
